// File: rtl/mul4x8x8_pkg.sv
// Shared constants, lane types and the 3:2 counter helper for the 4-lane int8 multiplier.
// Latency constant follows the MUL4X8X8_PIPE_EN macro.
package mul4x8x8_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int PROD_W = 16;

`ifdef MUL4X8X8_PIPE_EN
    localparam int PIPE_LAT = 2;
`else
    localparam int PIPE_LAT = 1;
`endif

    typedef logic [LANE_W-1:0] lane_op_t;
    typedef logic [PROD_W-1:0] lane_prod_t;

    typedef struct packed {
        lane_prod_t sum;
        lane_prod_t carry;
    } csa_t;

    // Row-wide full adder: three rows in, sum row and left-aligned carry row out.
    // Carries out of the MSB are dropped; the true product always fits in PROD_W bits.
    function automatic csa_t csa3(input lane_prod_t x, input lane_prod_t y, input lane_prod_t z);
        csa_t       r;
        lane_prod_t maj;
        maj     = (x & y) | (x & z) | (y & z);
        r.sum   = x ^ y ^ z;
        r.carry = {maj[PROD_W-2:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/mul8x8_wallace.sv
// One unsigned 8x8 lane: AND-array partial products, Wallace 3:2 reduction, final CPA.
// With MUL4X8X8_PIPE_EN the two reduced rows are registered before the CPA.
module mul8x8_wallace
    import mul4x8x8_pkg::*;
(
`ifdef MUL4X8X8_PIPE_EN
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ld_i,
`endif
    input  lane_op_t   a_i,
    input  lane_op_t   b_i,
    output lane_prod_t prod_o
);

    lane_prod_t pp_s [LANE_W];
    csa_t       l1a_s, l1b_s, l2a_s, l2b_s, l3_s, l4_s;
    csa_t       rows_s;

    // Partial-product rows, each shifted into its weight position.
    always_comb begin
        for (int i = 0; i < LANE_W; i++) begin
            pp_s[i] = lane_prod_t'(a_i & {LANE_W{b_i[i]}}) << i;
        end
    end

    // Wallace levels: 8 -> 6 -> 4 -> 3 -> 2 rows.
    assign l1a_s = csa3(pp_s[0], pp_s[1], pp_s[2]);
    assign l1b_s = csa3(pp_s[3], pp_s[4], pp_s[5]);
    assign l2a_s = csa3(l1a_s.sum, l1a_s.carry, l1b_s.sum);
    assign l2b_s = csa3(l1b_s.carry, pp_s[6], pp_s[7]);
    assign l3_s  = csa3(l2a_s.sum, l2a_s.carry, l2b_s.sum);
    assign l4_s  = csa3(l3_s.sum, l3_s.carry, l2b_s.carry);

`ifdef MUL4X8X8_PIPE_EN
    csa_t rows_q, rows_d;

    // Only accepted operands enter the stage register, so idle-cycle junk never reaches the CPA.
    always_comb begin
        if (ld_i) begin
            rows_d = l4_s;
        end else begin
            rows_d = rows_q;
        end
    end

    // Reduced-row stage register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q <= '{sum: 16'h0000, carry: 16'h0000};
        end else begin
            rows_q <= rows_d;
        end
    end

    assign rows_s = rows_q;
`else
    assign rows_s = l4_s;
`endif

    assign prod_o = rows_s.sum + rows_s.carry;

endmodule

// File: rtl/mul_4x8x8_wallace.sv
// Four-lane SIMD unsigned 8x8->16 multiplier with valid pipeline and held output register.
// Define MUL4X8X8_PIPE_EN for a two-stage pipeline (L=2); default is L=1.
module mul_4x8x8_wallace
    import mul4x8x8_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [LANES*LANE_W-1:0]    in_a,
    input  logic [LANES*LANE_W-1:0]    in_b,
    output logic                       out_valid,
    output logic [LANES*PROD_W-1:0]    product
);

    logic [LANES*PROD_W-1:0] prod_s;
    logic                    fin_valid_s;
    logic                    out_valid_q;
    logic [LANES*PROD_W-1:0] product_q, product_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_prod_t lane_prod_s;

        mul8x8_wallace u_lane (
`ifdef MUL4X8X8_PIPE_EN
            .clk_i  (clk),
            .rst_ni (rst_n),
            .ld_i   (in_valid),
`endif
            .a_i    (in_a[LANE_W*k +: LANE_W]),
            .b_i    (in_b[LANE_W*k +: LANE_W]),
            .prod_o (lane_prod_s)
        );

        assign prod_s[PROD_W*k +: PROD_W] = lane_prod_s;
    end

`ifdef MUL4X8X8_PIPE_EN
    logic s1_valid_q;

    // Valid bit tracking the reduced-row stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
        end
    end

    assign fin_valid_s = s1_valid_q;
`else
    assign fin_valid_s = in_valid;
`endif

    // Output register loads only with a valid result and holds otherwise.
    always_comb begin
        if (fin_valid_s) begin
            product_d = prod_s;
        end else begin
            product_d = product_q;
        end
    end

    // Output valid pulse and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            product_q   <= 64'h0000_0000_0000_0000;
        end else begin
            out_valid_q <= fin_valid_s;
            product_q   <= product_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mul_4x8x8_wallace.sv
// Directed self-checking bench for mul_4x8x8_wallace; adapts to either latency build.
module tb_mul_4x8x8_wallace;
    import mul4x8x8_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic [63:0] product;

    int errors = 0;
    int checks = 0;

    mul_4x8x8_wallace dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic [15:0] x, y;
        r = 64'h0;
        for (int k = 0; k < 4; k++) begin
            x = {8'h00, a[8*k +: 8]};
            y = {8'h00, b[8*k +: 8]};
            r[16*k +: 16] = x * y;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (product !== 64'h0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_pulse: cycle %0d got %b expected 0", c, out_valid); end
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int lat;
        lat = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        do begin
            step();
            lat++;
            if (lat == 1) begin in_valid = 1'b0; in_a = $urandom; in_b = $urandom; end
        end while (out_valid !== 1'b1 && lat < 8);
        checks++;
        if (out_valid !== 1'b1 || lat != PIPE_LAT) begin
            errors++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, PIPE_LAT);
        end
        checks++;
        if (product !== exp) begin errors++; $display("FAIL %s_product: got %h expected %h", name, product, exp); end
        step();
        checks++;
        if (out_valid !== 1'b0 || product !== exp) begin
            errors++; $display("FAIL %s_hold: got valid=%b product=%h expected valid=0 product=%h", name, out_valid, product, exp);
        end
    endtask

    task automatic test_vectors();
        run_vec("zero",     32'h0000_0000, 32'h0000_0000, 64'h0000_0000_0000_0000);
        run_vec("max",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFE01_FE01_FE01_FE01);
        run_vec("lane0",    32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_FE01);
        run_vec("isolate",  32'hFF00_0000, 32'h00FF_FFFF, 64'h0000_0000_0000_0000);
        run_vec("mixed",    32'h1234_5678, 32'h8765_4321, 64'h097E_1484_1682_0F78);
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [63:0] ve [10];
        int n_out;
        for (int i = 0; i < 10; i++) begin
            va[i] = $urandom; vb[i] = $urandom; ve[i] = golden(va[i], vb[i]);
        end
        n_out = 0;
        in_valid = 1'b1; in_a = va[0]; in_b = vb[0];
        for (int c = 0; c < 10 + PIPE_LAT + 3; c++) begin
            step();
            if (c + 1 < 10) begin
                in_a = va[c+1]; in_b = vb[c+1];
            end else begin
                in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (n_out >= 10 || c != n_out + PIPE_LAT - 1) begin
                    errors++; $display("FAIL stream_timing: pulse %0d at cycle %0d expected cycle %0d", n_out, c, n_out + PIPE_LAT - 1);
                end else if (product !== ve[n_out]) begin
                    errors++; $display("FAIL stream_product: index %0d got %h expected %h", n_out, product, ve[n_out]);
                end
                n_out++;
            end
        end
        checks++;
        if (n_out != 10) begin errors++; $display("FAIL stream_count: got %0d pulses expected 10", n_out); end
    endtask

    task automatic test_gaps();
        logic [15:0] pat;
        int idx;
        pat = 16'b1011_0010_0111_0001;
        for (int c = 0; c < 16 + PIPE_LAT + 1; c++) begin
            in_valid = (c < 16) ? pat[c] : 1'b0;
            in_a = $urandom; in_b = $urandom;
            step();
            idx = c - PIPE_LAT + 1;
            if (idx >= 0 && idx < 16) begin
                checks++;
                if (out_valid !== pat[idx]) begin
                    errors++; $display("FAIL gap_pattern: cycle %0d got %b expected %b", c, out_valid, pat[idx]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
        step();
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || product !== 64'h0) begin
            errors++; $display("FAIL midflight_reset: got valid=%b product=%h expected valid=0 product=0", out_valid, product);
        end
        rst_n = 1'b1;
        run_vec("after_release", 32'h0102_0304, 32'h0506_0708, 64'h0005_000C_0015_0020);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_gaps();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_4x8x8_wallace.md
# mul_4x8x8_wallace

SIMD multiplier: four independent unsigned 8×8 → 16-bit products per transaction, each computed by a Wallace-tree reduction of partial products. It is the multiply front end of the int8 vector MAC datapath. It accepts one 32-bit operand pair per cycle and returns four packed 16-bit products after a fixed pipeline latency.

## Interface
- Parameters: none. Lane count (4) and lane width (8) are fixed constants from the shared package.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid this cycle.
- in_a  input  32  four unsigned bytes; lane k = in_a[8k+7:8k].
- in_b  input  32  four unsigned bytes; lane k = in_b[8k+7:8k].
- out_valid  output  1  one-cycle pulse: product holds a new result.
- product  output  64  lane k result at product[16k+15:16k].

## Operation
- Per lane: product[16k+15:16k] = in_a[8k+7:8k] × in_b[8k+7:8k], unsigned.
- No overflow or truncation: max 0xFF×0xFF = 0xFE01.
- Lanes are fully independent; there is no carry between lanes.
- Each lane:
  - 8 partial-product rows (AND array).
  - Wallace reduction with full/half adders (3:2 and 2:2 counters) down to two rows.
  - Final carry-propagate add.
- Valid pipeline:
  - in_valid is sampled every cycle, with no back-pressure and no ready signal.
  - Each accepted pair produces exactly one out_valid pulse.
  - Results emerge in order.
- product register:
  - Loads only on the cycle its stage valid is set.
  - Otherwise holds the last result, so it stays stable after the out_valid pulse until the next result.
- Data registers with valid low must not change product.
- X on in_a/in_b while in_valid=0 must not propagate to product.

## Timing
- Reset (async assert, sync release):
  - out_valid=0, product=64'h0.
  - All internal valid bits are cleared.
  - Data registers may also clear to 0.
- Latency L=2 with the pipeline macro: pair sampled at edge N gives out_valid=1 and valid product after edge N+2.
  - Stage 1 registers the two reduced rows per lane.
  - Stage 2 registers the CPA sum.
- Throughput: one pair per cycle; back-to-back in_valid yields back-to-back out_valid with matching results.
- in_valid gaps propagate as out_valid gaps of equal length.
- Reset asserted mid-operation: in-flight transactions are discarded, and no out_valid appears for them after release.
- First in_valid on the cycle after reset release is accepted normally.

## Configuration
- MUL4X8X8_PIPE_EN defined:
  - Two-stage pipeline, L=2.
  - Register between the Wallace reduction and the CPA.
- MUL4X8X8_PIPE_EN undefined:
  - Reduction and CPA are combinational into one output register, L=1.
  - Identical results and handshake semantics otherwise.

## Structure
- Package mul4x8x8_pkg:
  - LANES=4, LANE_W=8, PROD_W=16.
  - Pipeline latency constant, which depends on the macro.
  - Typedefs for lane operand (8-bit) and lane product (16-bit).
- Sub-module mul8x8_wallace:
  - One unsigned 8×8 Wallace lane with an optional internal stage register.
  - Instantiated LANES times by generate.
  - The top holds the valid pipeline and output register.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, product=0; no spurious pulse after release.
- Extremes:
  - A=0x00000000, B=0x00000000 -> 0x0000000000000000.
  - A=B=0xFFFFFFFF -> 0xFE01FE01FE01FE01.
- Lane isolation:
  - A=B=0x000000FF -> 0x000000000000FE01.
  - A=0xFF000000, B=0x00FFFFFF -> 0x0000000000000000.
- Mixed: A=0x12345678, B=0x87654321 -> 0x097E148416820F78, with out_valid exactly L cycles after the in_valid pulse and product held afterwards.
- Streaming: 10 back-to-back vectors -> 10 consecutive out_valid pulses, each matching the per-byte golden model.
- Reset mid-flight: assert rst_n low one cycle after in_valid -> no out_valid for that vector, product=0.
